boothmul: RTL and testbench
===========================

BOOTHMUL -- requirements
Module: boothmul

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand width in bits; the product width is 2*WIDTH.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port num, input, WIDTH bits: multiplicand, two's-complement signed.
REQ-005 The block SHALL have port mul, input, WIDTH bits: multiplier, two's-complement signed.
REQ-006 The block SHALL have port ans, output, 2*WIDTH bits: signed product, registered.

Function
REQ-007 ans SHALL equal the full-precision signed product num*mul, sign-extended into 2*WIDTH bits, with no truncation or saturation.
REQ-008 The product SHALL be computed by radix-2 Booth recoding of mul over WIDTH iterations, unrolled combinationally:
- append an implicit 0 below mul bit 0;
- for each bit pair (mul[i], mul[i-1]): 01 adds num, 10 subtracts num, 00 and 11 leave the accumulator unchanged;
- arithmetic-shift the accumulator right by one after each step.
REQ-009 Latency SHALL be exactly 1 clock: ans after rising edge k SHALL reflect the num and mul values sampled at edge k.
REQ-010 A new operand pair SHALL be accepted on every clock, giving throughput 1/cycle. There is no handshake and no valid signal.
REQ-011 Between edges, ans SHALL hold its value regardless of input changes.
REQ-012 Boundary requirements:
- most-negative operands SHALL be exact, e.g. (-2^(W-1))*(-2^(W-1)) = 2^(2W-2);
- a zero operand SHALL yield 0;
- intermediate accumulation SHALL use at least 2*WIDTH+1 bits so no overflow occurs.
REQ-013 Internal combinational logic SHALL contain no latches and no combinational loops.

Reset
REQ-014 Assertion of rst_n (low) SHALL force ans to 0 immediately, without waiting for a clock edge.
REQ-015 While rst_n is low, ans SHALL stay 0.
REQ-016 On the first rising edge after rst_n deasserts, ans SHALL take the product of the inputs sampled at that edge.
REQ-017 Reset asserted mid-stream SHALL discard the pending result; no stale product SHALL appear after release.

Structure
REQ-018 A shared package boothmul_pkg SHALL hold the default WIDTH constant and the Booth recode encoding (NOP/ADD/SUB).
REQ-019 One sub-module, booth_stage, SHALL implement a single recode, add/subtract and arithmetic-shift step; boothmul SHALL instantiate WIDTH of them in a chain, followed by the output register.

Verification
REQ-020 The bench SHALL run at WIDTH=16 and compare every cycle against a signed behavioural reference delayed by one clock. It SHALL cover these directed scenarios:
- num=0x0008, mul=0xA482 -> ans=0xFFFD2410 one clock later.
- num=0x0024, mul=0x0064 -> ans=0x00000E10; num=0x0011, mul=0x00A0 -> ans=0x00000AA0; num=0x0052, mul=0x002C -> ans=0x00000E18.
- num=0x8000, mul=0x8000 -> ans=0x40000000; num=0x8000, mul=0x7FFF -> ans=0xC0008000; num=0xFFFF, mul=0xFFFF -> ans=0x00000001.
- Back-to-back new operands every cycle -> each result appears exactly one clock after its operands, with no skipped or repeated values.
- rst_n driven low between clock edges while ans=0x00000E10 -> ans=0 immediately; after release, the first product appears one clock later.
- Random signed operands, at least 10k vectors -> zero mismatches against the reference.

Source files
------------

// File: rtl/boothmul_pkg.sv
// -----------------------------------------------------------------------------
// boothmul_pkg
// Shared constants and types for the Booth multiplier:
//   DEFAULT_WIDTH : default operand width
//   booth_op_e    : radix-2 Booth recode encoding (NOP / ADD / SUB)
//   booth_recode  : maps a {current, previous} multiplier bit pair to an op
// -----------------------------------------------------------------------------
package boothmul_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'b00,
        BOOTH_ADD = 2'b01,
        BOOTH_SUB = 2'b10
    } booth_op_e;

    // pair = {mul[i], mul[i-1]}; 01 adds, 10 subtracts, 00/11 leave unchanged
    function automatic booth_op_e booth_recode(input logic [1:0] pair);
        booth_op_e op;
        case (pair)
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            2'b00:   op = BOOTH_NOP;
            2'b11:   op = BOOTH_NOP;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/boothmul_booth_stage.sv
// -----------------------------------------------------------------------------
// booth_stage
// One combinational radix-2 Booth step: recode, add/subtract, arithmetic shift.
// The working register is packed as {A[WIDTH:0], Q[WIDTH-1:0], q_prev}:
//   A      : (WIDTH+1)-bit signed partial accumulator (extra bit avoids overflow
//            when subtracting the most-negative multiplicand)
//   Q      : remaining multiplier bits, LSB is the current Booth bit
//   q_prev : previously examined multiplier bit (implicit 0 at start)
// Ports:
//   num_ext : input  [WIDTH:0]      sign-extended multiplicand
//   acc_in  : input  [2*WIDTH+1:0]  working register before this step
//   acc_out : output [2*WIDTH+1:0]  working register after add/sub and shift
// -----------------------------------------------------------------------------
module booth_stage
    import boothmul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]       num_ext,
    input  logic [2*WIDTH+1:0]   acc_in,
    output logic [2*WIDTH+1:0]   acc_out
);

    logic [WIDTH:0]   upper_s;
    logic [WIDTH:0]   sum_s;
    booth_op_e        op_s;

    assign upper_s = acc_in[2*WIDTH+1:WIDTH+1];
    assign op_s    = booth_recode(acc_in[1:0]);

    // Add or subtract the multiplicand into the upper accumulator half
    always_comb begin
        sum_s = upper_s;
        case (op_s)
            BOOTH_ADD: sum_s = upper_s + num_ext;
            BOOTH_SUB: sum_s = upper_s - num_ext;
            BOOTH_NOP: sum_s = upper_s;
            default:   sum_s = upper_s;
        endcase
    end

    // Arithmetic right shift of {sum, Q, q_prev}: q_prev drops out, sign replicates
    assign acc_out = {sum_s[WIDTH], sum_s, acc_in[WIDTH:1]};

endmodule

// File: rtl/boothmul.sv
// -----------------------------------------------------------------------------
// boothmul
// Single-cycle-latency signed multiplier using a fully unrolled chain of WIDTH
// radix-2 Booth stages followed by an output register. A new operand pair is
// accepted every clock; there is no handshake.
// Ports:
//   clk   : input               rising-edge clock
//   rst_n : input               asynchronous active-low reset, clears ans
//   num   : input  [WIDTH-1:0]  signed multiplicand
//   mul   : input  [WIDTH-1:0]  signed multiplier
//   ans   : output [2*WIDTH-1:0] registered signed product num*mul
// -----------------------------------------------------------------------------
module boothmul
    import boothmul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     num,
    input  logic [WIDTH-1:0]     mul,
    output logic [2*WIDTH-1:0]   ans
);

    logic [WIDTH:0]       num_ext_s;
    logic [2*WIDTH+1:0]   chain_s [0:WIDTH];
    logic [2*WIDTH-1:0]   product_s;
    logic                 unused_chain_bits_s;

    assign num_ext_s = {num[WIDTH-1], num};

    // Start state: A = 0, Q = multiplier, implicit 0 below multiplier bit 0
    assign chain_s[0] = {{(WIDTH+1){1'b0}}, mul, 1'b0};

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_stage
            booth_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .num_ext (num_ext_s),
                .acc_in  (chain_s[g]),
                .acc_out (chain_s[g+1])
            );
        end
    endgenerate

    // Product is the low 2*WIDTH bits of {A, Q}; the top A bit is only a
    // redundant sign copy and the trailing bit is the last examined multiplier bit
    assign product_s           = chain_s[WIDTH][2*WIDTH:1];
    assign unused_chain_bits_s = chain_s[WIDTH][2*WIDTH+1] ^ chain_s[WIDTH][0];

    // Output register: cleared immediately on reset, otherwise captures the product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ans <= {(2*WIDTH){1'b0}};
        end else begin
            ans <= product_s;
        end
    end

endmodule

// File: tb/tb_boothmul.sv
// -----------------------------------------------------------------------------
// tb_boothmul
// Self-checking bench for boothmul at WIDTH=16. Expected products are pushed to
// a scoreboard queue when operands are driven and popped when the result is due.
// -----------------------------------------------------------------------------
module tb_boothmul;

    localparam int W = 16;

    logic            clk;
    logic            rst_n;
    logic [W-1:0]    num;
    logic [W-1:0]    mul;
    logic [2*W-1:0]  ans;

    int              total;
    int              bad;
    logic [2*W-1:0]  sb [$];

    boothmul #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .num   (num),
        .mul   (mul),
        .ans   (ans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural signed reference
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0]   sa;
        logic signed [W-1:0]   sbv;
        logic signed [2*W-1:0] p;
        sa  = a;
        sbv = b;
        p   = sa * sbv;
        return p;
    endfunction

    // Drive one operand pair just after a falling edge and queue its expected product
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] e);
        @(negedge clk);
        num = a;
        mul = b;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [2*W-1:0] got;
        rst_n = 1'b0;
        num   = 16'h1234;
        mul   = 16'h0567;
        #1;
        total++;
        if (ans !== 32'h0) begin
            bad++;
            $display("FAIL reset_initial: ans=%h expected=%h", ans, 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ans !== 32'h0) begin
            bad++;
            $display("FAIL reset_held: ans=%h expected=%h", ans, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h0003, 16'hFFFB, ref_mul(16'h0003, 16'hFFFB));
        @(posedge clk);
        #1;
        got = sb.pop_front();
        total++;
        if (ans !== got) begin
            bad++;
            $display("FAIL reset_first_product: ans=%h expected=%h", ans, got);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]   na [7];
        logic [W-1:0]   ma [7];
        logic [2*W-1:0] ea [7];
        logic [2*W-1:0] got;
        na = '{16'h0008, 16'h0024, 16'h0011, 16'h0052, 16'h8000, 16'h8000, 16'hFFFF};
        ma = '{16'hA482, 16'h0064, 16'h00A0, 16'h002C, 16'h8000, 16'h7FFF, 16'hFFFF};
        ea = '{32'hFFFD2410, 32'h00000E10, 32'h00000AA0, 32'h00000E18,
               32'h40000000, 32'hC0008000, 32'h00000001};
        for (int i = 0; i < 7; i++) begin
            drive(na[i], ma[i], ea[i]);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            total++;
            if (ans !== got) begin
                bad++;
                $display("FAIL directed_%0d: num=%h mul=%h ans=%h expected=%h", i, na[i], ma[i], ans, got);
            end
        end
    endtask

    task automatic test_zero();
        logic [W-1:0]   na [4];
        logic [W-1:0]   ma [4];
        logic [2*W-1:0] got;
        na = '{16'h0000, 16'h7FFF, 16'h0000, 16'h8000};
        ma = '{16'h8000, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            drive(na[i], ma[i], 32'h0);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            total++;
            if (ans !== got) begin
                bad++;
                $display("FAIL zero_%0d: num=%h mul=%h ans=%h expected=%h", i, na[i], ma[i], ans, got);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] got;
        logic [2*W-1:0] held;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        for (int i = 0; i < 20; i++) begin
            a = 16'(i * 16'h0123 + 16'h0007);
            b = 16'(16'hF000 + i * 16'h0211);
            drive(a, b, ref_mul(a, b));
            // inputs just changed mid-cycle: registered output must not follow them
            if (i > 0) begin
                #1;
                total++;
                if (ans !== held) begin
                    bad++;
                    $display("FAIL b2b_hold_%0d: ans=%h expected=%h", i, ans, held);
                end
            end
            @(posedge clk);
            #1;
            got = sb.pop_front();
            total++;
            if (ans !== got) begin
                bad++;
                $display("FAIL b2b_%0d: ans=%h expected=%h", i, ans, got);
            end
            held = ans;
        end
    endtask

    task automatic test_async_reset();
        logic [2*W-1:0] got;
        drive(16'h0024, 16'h0064, 32'h00000E10);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        total++;
        if (ans !== got) begin
            bad++;
            $display("FAIL areset_pre: ans=%h expected=%h", ans, got);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ans !== 32'h0) begin
            bad++;
            $display("FAIL areset_immediate: ans=%h expected=%h", ans, 32'h0);
        end
        @(posedge clk);
        #1;
        total++;
        if (ans !== 32'h0) begin
            bad++;
            $display("FAIL areset_hold: ans=%h expected=%h", ans, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        num   = 16'h0052;
        mul   = 16'h002C;
        sb.push_back(32'h00000E18);
        #1;
        total++;
        if (ans !== 32'h0) begin
            bad++;
            $display("FAIL areset_no_stale: ans=%h expected=%h", ans, 32'h0);
        end
        @(posedge clk);
        #1;
        got = sb.pop_front();
        total++;
        if (ans !== got) begin
            bad++;
            $display("FAIL areset_release: ans=%h expected=%h", ans, got);
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] got;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        for (int i = 0; i < 10000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            drive(a, b, ref_mul(a, b));
            @(posedge clk);
            #1;
            got = sb.pop_front();
            total++;
            if (ans !== got) begin
                bad++;
                $display("FAIL random_%0d: num=%h mul=%h ans=%h expected=%h", i, a, b, ans, got);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_zero();
        test_back_to_back();
        test_async_reset();
        test_random();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d expected=%0d", sb.size(), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
